// File: rtl/toggle_monitor_if.sv
// Read-side handshake of toggle_monitor: show-ahead head record with valid/ready pop.
interface toggle_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_level;
  logic [CNT_W-1:0] rd_len;

  modport master (output rd_valid, output rd_level, output rd_len, input rd_ready);
  modport slave  (input rd_valid, input rd_level, input rd_len, output rd_ready);
endinterface

// File: rtl/toggle_monitor.sv
// Measures constant-level run lengths on an asynchronous line and queues
// {level, length} records in a small show-ahead FIFO drained by a host.
module toggle_monitor #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   d_in,
  input  logic                   en,
  input  logic                   clr_ovf,
  toggle_monitor_if.master       rd,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] len;
  } rec_t;

  logic             s1_q, s2_q, s3_q;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  rec_t             mem_q [DEPTH];
  rec_t             hold_q;
  rec_t             head_c;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic edge_c, push_c, pop_c, wr_c, drop_c, empty_c, full_c;

  assign edge_c  = s2_q ^ s3_q;
  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign push_c  = en && armed_q && edge_c;
  assign pop_c   = !empty_c && rd.rd_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_c    = push_c && (!full_c || pop_c);
  assign drop_c  = push_c && full_c && !pop_c;
  assign head_c  = mem_q[rd_ptr_q];

  // Arming and run-length counting; the first edge only starts a run.
  always_comb begin
    armed_d   = armed_q;
    run_cnt_d = run_cnt_q;
    if (!en) begin
      armed_d   = 1'b0;
      run_cnt_d = '0;
    end else if (!armed_q) begin
      if (edge_c) begin
        armed_d   = 1'b1;
        run_cnt_d = CNT_W'(1);
      end
    end else if (edge_c) begin
      run_cnt_d = CNT_W'(1);
    end else if (run_cnt_q != CNT_MAX) begin
      run_cnt_d = run_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({wr_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky overflow; a coincident drop beats the clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop_c)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      armed_q   <= 1'b0;
      run_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      hold_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      s1_q      <= d_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      armed_q   <= armed_d;
      run_cnt_q <= run_cnt_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      if (!empty_c) hold_q <= head_c;
      if (wr_c) begin
        mem_q[wr_ptr_q] <= '{level: s3_q, len: run_cnt_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Show-ahead head while non-empty; otherwise the last head seen is held.
  assign rd.rd_valid = !empty_c;
  assign rd.rd_level = empty_c ? hold_q.level : head_c.level;
  assign rd.rd_len   = empty_c ? hold_q.len   : head_c.len;
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// Self-checking bench for toggle_monitor: directed scenarios plus a randomized
// run-length stream compared against a queue of expected records.
module tb_toggle_monitor;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SAT   = (1 << CNT_W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         d_in;
  logic         en;
  logic         clr_ovf;
  logic [2:0]   fifo_count;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [CNT_W:0] got[$];
  logic [CNT_W:0] exp_q[$];

  toggle_monitor_if #(.CNT_W(CNT_W)) rd_if ();

  toggle_monitor #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .en         (en),
    .clr_ovf    (clr_ovf),
    .rd         (rd_if.master),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Host-side capture of every popped record, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && rd_if.rd_valid && rd_if.rd_ready)
      got.push_back({rd_if.rd_level, rd_if.rd_len});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic toggle();
    d_in = ~d_in;
  endtask

  task automatic quiesce();
    en          = 1'b0;
    clr_ovf     = 1'b0;
    rd_if.rd_ready = 1'b1;
    d_in        = 1'b0;
    hold(8);
    got.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; d_in = 1'b0; en = 1'b0; clr_ovf = 1'b0; rd_if.rd_ready = 1'b0;
    hold(3);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (rd_if.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", rd_if.rd_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    n_cmp++; if ({rd_if.rd_level, rd_if.rd_len} !== '0) begin n_err++; $display("FAIL reset_head: got %0d/%0d expected 0/0", rd_if.rd_level, rd_if.rd_len); end
  endtask

  task automatic test_basic();
    logic [CNT_W:0] e;
    quiesce();
    en = 1'b1;
    toggle();
    for (int i = 0; i < 6; i++) begin hold(5); toggle(); end
    hold(8);
    n_cmp++; if (got.size() !== 6) begin n_err++; $display("FAIL basic_count: got %0d expected 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      e = {(i % 2 == 0) ? 1'b1 : 1'b0, CNT_W'(5)};
      n_cmp++; if (got[i] !== e) begin n_err++; $display("FAIL basic_rec%0d: got %h expected %h", i, got[i], e); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_saturate();
    logic [CNT_W:0] e;
    quiesce();
    en = 1'b1;
    toggle(); hold(5); toggle(); hold(300); toggle(); hold(8);
    n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL sat_count: got %0d expected 2", got.size()); end
    if (got.size() >= 2) begin
      e = {1'b0, CNT_W'(SAT)};
      n_cmp++; if (got[1] !== e) begin n_err++; $display("FAIL sat_rec: got %h expected %h", got[1], e); end
    end
  endtask

  task automatic test_overflow();
    logic [CNT_W:0] e;
    quiesce();
    rd_if.rd_ready = 1'b0;
    en = 1'b1;
    toggle();
    for (int i = 0; i < 5; i++) begin hold(4); toggle(); end
    hold(5);
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    rd_if.rd_ready = 1'b1;
    hold(6);
    n_cmp++; if (got.size() !== 4) begin n_err++; $display("FAIL ovf_drain: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      e = {(i % 2 == 0) ? 1'b1 : 1'b0, CNT_W'(4)};
      n_cmp++; if (got[i] !== e) begin n_err++; $display("FAIL ovf_rec%0d: got %h expected %h", i, got[i], e); end
    end
    n_cmp++; if (rd_if.rd_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b expected 0", rd_if.rd_valid); end
    e = {1'b0, CNT_W'(4)};
    n_cmp++; if ({rd_if.rd_level, rd_if.rd_len} !== e) begin n_err++; $display("FAIL ovf_holdhead: got %h expected %h", {rd_if.rd_level, rd_if.rd_len}, e); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [CNT_W:0] e;
    quiesce();
    rd_if.rd_ready = 1'b0;
    en = 1'b1;
    toggle();
    for (int i = 0; i < 4; i++) begin hold(5); toggle(); end
    hold(7);
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_pre: got %0d expected 4", fifo_count); end
    toggle();
    hold(2);
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    tick();
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_ovf: got %b expected 0", overflow); end
    rd_if.rd_ready = 1'b1;
    hold(8);
    n_cmp++; if (got.size() !== 5) begin n_err++; $display("FAIL full_drain: got %0d expected 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      e = {(i % 2 == 0) ? 1'b1 : 1'b0, CNT_W'((i == 4) ? 7 : 5)};
      n_cmp++; if (got[i] !== e) begin n_err++; $display("FAIL full_rec%0d: got %h expected %h", i, got[i], e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [CNT_W:0] e;
    quiesce();
    rd_if.rd_ready = 1'b0;
    en = 1'b1;
    toggle();
    for (int i = 0; i < 3; i++) begin hold(4); toggle(); end
    hold(5);
    n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL rstmid_pre: got %0d expected 3", fifo_count); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (rd_if.rd_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", rd_if.rd_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf: got %b expected 0", overflow); end
    #2 rst_n = 1'b1;
    tick();
    rd_if.rd_ready = 1'b1;
    hold(4); toggle(); hold(5); toggle(); hold(8);
    n_cmp++; if (got.size() !== 1) begin n_err++; $display("FAIL rstmid_recs: got %0d expected 1", got.size()); end
    if (got.size() >= 1) begin
      e = {1'b1, CNT_W'(5)};
      n_cmp++; if (got[0] !== e) begin n_err++; $display("FAIL rstmid_rec: got %h expected %h", got[0], e); end
    end
  endtask

  task automatic test_enable();
    logic [CNT_W:0] e;
    quiesce();
    en = 1'b1;
    toggle(); hold(5); toggle(); hold(5);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin toggle(); hold(4); end
    hold(4);
    n_cmp++; if (got.size() !== 1) begin n_err++; $display("FAIL en_window: got %0d expected 1", got.size()); end
    en = 1'b1;
    hold(3); toggle(); hold(6); toggle(); hold(8);
    n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL en_rearm: got %0d expected 2", got.size()); end
    if (got.size() >= 2) begin
      e = {1'b1, CNT_W'(6)};
      n_cmp++; if (got[1] !== e) begin n_err++; $display("FAIL en_rec: got %h expected %h", got[1], e); end
    end
  endtask

  task automatic test_random();
    int n, low_run;
    quiesce();
    exp_q.delete();
    low_run = 0;
    en = 1'b1;
    toggle();
    for (int r = 0; r < 30; r++) begin
      n = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(3, 12));
      for (int c = 0; c < n; c++) begin
        // Host stalls at most two cycles in a row, so the FIFO never fills.
        if (low_run >= 2 || $urandom_range(0, 2) != 0) begin rd_if.rd_ready = 1'b1; low_run = 0; end
        else begin rd_if.rd_ready = 1'b0; low_run++; end
        tick();
      end
      exp_q.push_back({d_in, CNT_W'((n > int'(SAT)) ? int'(SAT) : n)});
      toggle();
    end
    rd_if.rd_ready = 1'b1;
    hold(10);
    n_cmp++; if (got.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_rec%0d: got %h expected %h", i, got[i], exp_q[i]); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rand_ovf: got %b expected 0", overflow); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
